// File: rtl/pac_pkg.sv
// Shared constants for the maze collision arbiter: directions, screen size,
// FSM encoding and requester indices.
package pac_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_e;

   localparam logic [10:0] SCREEN_W = 11'd640;
   localparam logic [9:0]  SCREEN_H = 10'd480;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic [1:0] REQ_PAC_TURN = 2'd0;
   localparam logic [1:0] REQ_PAC_MOVE = 2'd1;
   localparam logic [1:0] REQ_GHOST_A  = 2'd2;
   localparam logic [1:0] REQ_GHOST_B  = 2'd3;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   logic [1:0] cand;

   // Scan from farthest to nearest offset so the nearest hit wins.
   always_comb begin
      gnt_idx   = ptr;
      gnt_valid = 1'b0;
      cand      = ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) begin
            gnt_idx   = cand;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/collision_arbiter.sv
// Serialises wall-collision queries from four sprites onto one maze ROM port.
//
// state    | meaning
// ST_IDLE  | waiting for a request; round-robin grant and input latch
// ST_ISSUE | probe point computed; ROM read issued when the probe is on screen
// ST_WAIT  | ROM data returns; permit/blocked result registered
// ST_RESP  | one-cycle ack to the granted requester with the result
module collision_arbiter
   import pac_pkg::*;
#(
   parameter int TILE_SHIFT = 3,
   parameter int MAZE_COLS  = 80,
   parameter int MAZE_ROWS  = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [39:0] req_x,
   input  logic [35:0] req_y,
   input  logic [7:0]  req_dir,
   output logic [3:0]  ack,
   output logic        result,
   output logic        rom_en,
   output logic [12:0] rom_addr,
   input  logic        rom_data,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [1:0]  idx_q, idx_d;
   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic [1:0]  dir_q, dir_d;
   logic        result_q, result_d;

   logic [1:0]  gnt_idx;
   logic        gnt_valid;
   logic [9:0]  xs   [4];
   logic [8:0]  ys   [4];
   logic [1:0]  dirs [4];

   logic [10:0] px;
   logic [9:0]  py;
   logic        edge_blk;
   logic        probe_ok;
   logic [12:0] probe_addr;

   rr_arbiter4 u_rr (
      .req       (req),
      .ptr       (rr_ptr_q),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         xs[i]   = req_x[10*i +: 10];
         ys[i]   = req_y[9*i +: 9];
         dirs[i] = req_dir[2*i +: 2];
      end
   end

   // Probe is derived from the latched query, so it stays stable through WAIT.
   always_comb begin
      px       = {1'b0, x_q};
      py       = {1'b0, y_q};
      edge_blk = 1'b0;
      case (dir_q)
         DIR_UP:    if (y_q == '0) edge_blk = 1'b1; else py = {1'b0, y_q} - 10'd1;
         DIR_DOWN:  py = {1'b0, y_q} + 10'd1;
         DIR_LEFT:  if (x_q == '0) edge_blk = 1'b1; else px = {1'b0, x_q} - 11'd1;
         default:   px = {1'b0, x_q} + 11'd1;
      endcase
      probe_ok   = !edge_blk && (px < SCREEN_W) && (py < SCREEN_H);
      probe_addr = 13'(py >> TILE_SHIFT) * 13'(MAZE_COLS) + 13'(px >> TILE_SHIFT);
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      x_d      = x_q;
      y_d      = y_q;
      dir_d    = dir_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d  = ST_ISSUE;
               rr_ptr_d = gnt_idx + 2'd1;
               idx_d    = gnt_idx;
               x_d      = xs[gnt_idx];
               y_d      = ys[gnt_idx];
               dir_d    = dirs[gnt_idx];
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            state_d  = ST_RESP;
            result_d = probe_ok & ~rom_data;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         dir_q    <= '0;
         result_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dir_q    <= dir_d;
         result_q <= result_d;
      end
   end

   // Outputs decode from registered state so reset clears them at once.
   assign busy     = (state_q != ST_IDLE);
   assign rom_en   = (state_q == ST_ISSUE) && probe_ok;
   assign rom_addr = rom_en ? probe_addr : '0;
   assign ack      = (state_q == ST_RESP) ? (4'b0001 << idx_q) : 4'b0000;
   assign result   = (state_q == ST_RESP) && result_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter: grants, ROM addressing, edges, reset.
module tb_collision_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [39:0] req_x;
   logic [35:0] req_y;
   logic [7:0]  req_dir;
   logic [3:0]  ack;
   logic        result;
   logic        rom_en;
   logic [12:0] rom_addr;
   logic        rom_data;
   logic        busy;

   int tests = 0;
   int fails = 0;

   collision_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_x    (req_x),
      .req_y    (req_y),
      .req_dir  (req_dir),
      .ack      (ack),
      .result   (result),
      .rom_en   (rom_en),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_q(input int i, input int x, input int y, input int d);
      req_x[10*i +: 10] = 10'(x);
      req_y[9*i +: 9]   = 9'(y);
      req_dir[2*i +: 2] = 2'(d);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; req = '0; req_x = '0; req_y = '0; req_dir = '0; rom_data = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_result", result, 0);
      tick();
      rst = 1'b1;

      // Requester 1 moving up from (320,146): tile (40,18)
      set_q(1, 320, 146, 0);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      req_x = '1; req_y = '1; req_dir = '1;
      #1;
      chk("t1_busy", busy, 1);
      chk("t1_rom_en", rom_en, 1);
      chk("t1_rom_addr", rom_addr, 1480);
      chk("t1_ack_issue", ack, 0);
      tick();
      chk("t1_rom_en_wait", rom_en, 0);
      chk("t1_ack_wait", ack, 0);
      tick();
      chk("t1_ack", ack, 4'b0010);
      chk("t1_result", result, 1);
      tick();
      chk("t1_ack_idle", ack, 0);
      chk("t1_busy_idle", busy, 0);

      // All four requesting: rotation and 4-clock spacing
      do_reset();
      for (int i = 0; i < 4; i++) set_q(i, 100, 100, 3);
      rom_data = 1'b0;
      req = 4'b1111;
      tick(); tick(); tick();
      chk("rr_ack0", ack, 4'b0001);
      for (int n = 1; n < 5; n++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            chk("rr_gap", ack, 0);
         end
         tick();
         if (n == 4) req = 4'b0000;
         chk("rr_ack", ack, 4'b0001 << (n % 4));
      end
      tick();
      chk("rr_idle_busy", busy, 0);

      // Requester 0 at left edge moving left: no ROM read, blocked
      set_q(0, 0, 100, 2);
      rom_data = 1'b0;
      req = 4'b0001;
      tick();
      req = 4'b0000;
      chk("edge_l_rom_en", rom_en, 0);
      chk("edge_l_busy", busy, 1);
      tick();
      chk("edge_l_rom_en_w", rom_en, 0);
      tick();
      chk("edge_l_ack", ack, 4'b0001);
      chk("edge_l_result", result, 0);
      tick();

      // Requester 3 moving right into a wall
      set_q(3, 100, 200, 3);
      rom_data = 1'b1;
      req = 4'b1000;
      tick();
      req = 4'b0000;
      chk("g3_rom_en", rom_en, 1);
      chk("g3_rom_addr", rom_addr, 2012);
      tick();
      tick();
      chk("g3_ack", ack, 4'b1000);
      chk("g3_result", result, 0);
      tick();

      // Requester 2 at right screen edge: probe x = 640 is off screen
      set_q(2, 639, 10, 3);
      rom_data = 1'b0;
      req = 4'b0100;
      tick();
      req = 4'b0000;
      chk("edge_r_rom_en", rom_en, 0);
      tick(); tick();
      chk("edge_r_ack", ack, 4'b0100);
      chk("edge_r_result", result, 0);
      tick();

      // Requester 1 at the last tile: address 59*80+79
      set_q(1, 638, 479, 3);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      chk("max_rom_addr", rom_addr, 4799);
      tick(); tick();
      chk("max_ack", ack, 4'b0010);
      chk("max_result", result, 1);
      tick();

      // Requester 2 moving down off the bottom
      set_q(2, 50, 479, 1);
      req = 4'b0100;
      tick();
      req = 4'b0000;
      chk("edge_d_rom_en", rom_en, 0);
      tick(); tick();
      chk("edge_d_result", result, 0);
      tick();

      // Reset during WAIT aborts the query and clears the round-robin pointer
      set_q(1, 100, 100, 3);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      chk("abort_busy_pre", busy, 1);
      rst = 1'b0;
      #1;
      chk("abort_ack", ack, 0);
      chk("abort_rom_en", rom_en, 0);
      chk("abort_busy", busy, 0);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("abort_no_ack", ack, 0);
      end
      for (int i = 0; i < 4; i++) set_q(i, 100, 100, 3);
      req = 4'b1111;
      tick(); tick(); tick();
      req = 4'b0000;
      chk("abort_first_gnt", ack, 4'b0001);
      tick();

      // Requester 2 drops req in ISSUE while requester 1 raises it
      req = 4'b0100;
      tick();
      req = 4'b0010;
      tick(); tick();
      chk("drop_ack2", ack, 4'b0100);
      tick();
      chk("drop_idle", busy, 0);
      tick();
      req = 4'b0000;
      chk("drop_gnt1_busy", busy, 1);
      tick(); tick();
      chk("drop_ack1", ack, 4'b0010);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
